// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier: one partial product per CALC cycle, 2N-bit result.
// Optional early termination once the remaining multiplier bits are zero: define MUL_SEQ_EARLY_EXIT_EN.
module mul_seq #(
    parameter int N = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           soc,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           eoc,
    output logic [2*N-1:0] p
);

    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [2*N-1:0]   md;
    logic [N-1:0]     mr;
    logic [2*N-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             last_step;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            md    <= '0;
            mr    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (soc) begin
                        md  <= {{N{1'b0}}, x};
                        mr  <= y;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + (mr[0] ? md : '0);
                    md  <= md << 1;
                    mr  <= mr >> 1;
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // The run finishes on the edge that consumes the last meaningful multiplier bit.
    always_comb begin
        last_step = (cnt == LAST_CNT);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        last_step = last_step || ((mr >> 1) == '0);
`endif
        next_state = state;
        case (state)
            IDLE:    if (soc) next_state = CALC;
            CALC:    if (last_step) next_state = DONE;
            DONE:    if (!soc) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign eoc = (state != CALC);
    assign p   = acc;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver queues the expected product and latency per run,
// a negedge monitor compares whenever a busy period ends.
module tb_mul_seq;

    localparam int N = 8;

    typedef struct {
        logic [2*N-1:0] prod;
        int             lat;
    } exp_t;

    logic           clock;
    logic           reset;
    logic           soc;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           eoc;
    logic [2*N-1:0] p;

    exp_t sb[$];
    int   checks;
    int   fails;
    int   busy;

    mul_seq #(.N(N)) dut (
        .clock(clock),
        .reset(reset),
        .soc  (soc),
        .x    (x),
        .y    (y),
        .eoc  (eoc),
        .p    (p)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference latency: N cycles, or the position of y's top set bit when exiting early.
    function automatic int exp_latency(input int yv);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        int hb = 0;
        for (int i = 0; i < N; i++)
            if (((yv >> i) & 1) != 0) hb = i + 1;
        return (hb < 1) ? 1 : hb;
`else
        return N;
`endif
    endfunction

    // Monitor: counts busy negedges and checks the result when eoc returns high.
    always @(negedge clock) begin
        if (reset) begin
            busy = 0;
        end else if (!eoc) begin
            busy++;
        end else if (busy > 0) begin
            if (sb.size() == 0) begin
                check_output("spurious_completion", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("product", p, e.prod);
                check_output("latency", busy, e.lat);
            end
            busy = 0;
        end
    end

    // Starts a run from IDLE/DONE, scrambles inputs while busy, returns at the negedge eoc is back.
    task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        bit   done_seen;
        @(negedge clock);
        soc = 1'b1;
        x   = a;
        y   = b;
        e.prod = (2*N)'(longint'(a) * longint'(b));
        e.lat  = exp_latency(int'(b));
        sb.push_back(e);
        done_seen = 0;
        for (int i = 0; i < N + 4 && !done_seen; i++) begin
            @(negedge clock);
            if (eoc) begin
                soc = 1'b0;
                done_seen = 1;
            end else begin
                soc = 1'($urandom_range(0, 1));
                x   = N'($urandom);
                y   = N'($urandom);
            end
        end
        if (!done_seen) begin
            check_output("completion_timeout", 0, 1);
            soc = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        checks = 0;
        fails  = 0;
        busy   = 0;
        reset  = 1'b1;
        soc    = 1'b1;
        x      = 8'd13;
        y      = 8'd11;

        // Reset held with soc active: must stay idle with a cleared product.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_output("reset_eoc", eoc, 1);
            check_output("reset_p", p, 0);
        end
        soc   = 1'b0;
        reset = 1'b0;

        apply_stimulus(8'd13, 8'd11);

        // DONE must hold while soc stays high.
        for (int i = 0; i < 5; i++) begin
            soc = 1'b1;
            @(negedge clock);
            check_output("hold_eoc", eoc, 1);
            check_output("hold_p", p, 143);
        end
        soc = 1'b0;

        apply_stimulus(8'd7, 8'd9);
        apply_stimulus(8'd255, 8'd255);
        apply_stimulus(8'd0, 8'd200);
        apply_stimulus(8'd200, 8'd0);
        apply_stimulus(8'd5, 8'd1);
        apply_stimulus(8'd5, 8'h80);

        // Product persists through IDLE.
        repeat (3) @(negedge clock);
        check_output("idle_keeps_p", p, 640);
        check_output("idle_eoc", eoc, 1);

        // Abort a run in its third CALC cycle with an asynchronous reset.
        @(negedge clock);
        soc = 1'b1;
        x   = 8'd13;
        y   = 8'd11;
        @(negedge clock);
        soc = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        check_output("pre_abort_busy", eoc, 0);
        reset = 1'b1;
        #1;
        check_output("async_reset_eoc", eoc, 1);
        check_output("async_reset_p", p, 0);
        soc = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        soc   = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_output("post_reset_eoc", eoc, 1);
            check_output("post_reset_p", p, 0);
        end

        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i % 5 == 0) rb = N'(1) << $urandom_range(0, N - 1);
            apply_stimulus(ra, rb);
        end

        repeat (3) @(negedge clock);
        check_output("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand width in bits (N >= 2).
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 soc  input  1  start of conversion, driven by the consumer.
REQ-005 x  input  N  multiplicand, natural in base 2.
REQ-006 y  input  N  multiplier, natural in base 2.
REQ-007 eoc  output  1  end of conversion; 1 = idle/result valid, 0 = busy.
REQ-008 p  output  2N  product register; value is x*y when eoc=1 after a run.

Function
REQ-009 SHALL implement a shift-and-add sequential multiplier with four registers:
- MD, 2N bits, shifting multiplicand
- MR, N bits, shifting multiplier
- P, 2N bits, accumulator driving p
- CNT, ceil(log2 N)+1 bits, iteration count
REQ-010 SHALL use a 3-state FSM: IDLE (eoc=1), CALC (eoc=0), DONE (eoc=1).
REQ-011 IDLE with soc=0: SHALL hold all registers.
REQ-012 IDLE with soc=1 at an edge: SHALL load MD={N'0,x}, MR=y, P=0 and CNT=0, and go to CALC.
REQ-013 Each CALC edge SHALL update all four registers in the same edge:
- P <= P + (MR[0] ? MD : 0), modulo 2^2N with no overflow possible
- MD <= MD<<1
- MR <= MR>>1
- CNT <= CNT+1
REQ-014 CALC SHALL go to DONE on the edge where CNT==N-1, i.e. after exactly N CALC cycles, except as given in REQ-022.
REQ-015 Latency: with soc sampled 1 at edge k, eoc SHALL be 0 from edge k to k+N and return to 1 at edge k+N, with p=x*y at that edge.
REQ-016 x and y SHALL be sampled only at the start edge; later changes SHALL NOT affect the result.
REQ-017 soc SHALL be ignored while in CALC.
REQ-018 DONE SHALL hold P; it SHALL stay in DONE while soc=1 (no automatic restart) and go to IDLE on the first edge with soc=0.
REQ-019 p SHALL keep the last product through DONE and IDLE until the next start edge clears it.
REQ-020 Boundary cases:
- x=0 or y=0 SHALL still take the full latency and give p=0.
- x=y=2^N-1 SHALL give p=(2^N-1)^2 with no truncation.

Reset
REQ-021 While reset=1 the block SHALL, immediately and without waiting for a clock edge:
- go to IDLE
- set eoc=1, p=0 and MD=MR=CNT=0
- abort any run in progress without signalling completion
- ignore soc for as long as reset is held

Configuration
REQ-022 Macro MUL_SEQ_EARLY_EXIT_EN controls early termination:
- Defined: CALC SHALL go to DONE on the first edge where the shifted MR (MR>>1) equals 0, or CNT==N-1, whichever comes first; latency is max(1, index of y's highest set bit + 1) cycles, and 1 cycle for y=0.
- Undefined: latency SHALL be exactly N cycles for every operand pair.
- The result p SHALL be identical in both builds.

Verification
REQ-023 reset=1 with soc=1 and a clock running -> eoc=1, p=0 throughout; no transition out of IDLE.
REQ-024 N=8, x=13, y=11, soc pulse -> eoc=0 for 8 cycles, then eoc=1 with p=143 (macro undefined).
REQ-025 N=8, x=255, y=255 -> p=65025; x=0, y=200 -> p=0 after the full 8 cycles.
REQ-026 soc held 1 after completion for 5 cycles -> eoc stays 1 and p holds 143. Then soc=0, followed by soc=1 with x=7, y=9 -> p=63.
REQ-027 reset asserted mid-operation (3rd CALC cycle of x=13, y=11) -> eoc=1 and p=0 asynchronously. After release, IDLE with no spurious completion.
REQ-028 Macro defined, N=8, x=5, y=1 -> eoc=1 after 1 cycle with p=5. With x=5, y=0x80 -> 8 cycles, p=640.
